// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave memory: pipelined address/data phases, programmable wait states,
// two-cycle ERROR response, byte-lane writes and completed-transfer counters.
module ahb_slave_mem #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  input  logic [3:0]       wait_cycles,
  output logic [31:0]      HRDATA,
  output logic             HREADYOUT,
  output logic [1:0]       HRESP,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  logic [31:0] mem [MEM_DEPTH];

  state_e           st_q, st_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [3:0]       be_q, be_d;
  logic             write_q, write_d;
  logic             hready_q, hready_d;
  logic [1:0]       hresp_q, hresp_d;
  logic [31:0]      hrdata_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;

  logic                 can_accept, accept, addr_err;
  logic [ADDR_BITS-3:0] a_word;
  logic [3:0]           a_be;
  logic                 data_wr, data_rd;
  logic [31:0]          rd_word;

  assign a_word = HADDR[ADDR_BITS-1:2];

  always_comb begin
    addr_err = 1'b0;
    if (32'(a_word) >= MEM_DEPTH)                 addr_err = 1'b1;
    if (HADDR[31:ADDR_BITS] != '0)                addr_err = 1'b1;
    if (HSIZE > 3'd2)                             addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])                addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)     addr_err = 1'b1;
  end

  always_comb begin
    case (HSIZE)
      3'd0:    a_be = 4'b0001 << HADDR[1:0];
      3'd1:    a_be = HADDR[1] ? 4'b1100 : 4'b0011;
      default: a_be = 4'b1111;
    endcase
  end

  // New address phases are only taken in cycles where this slave drives HREADYOUT high.
  assign can_accept = (st_q == StIdle) || (st_q == StData) || (st_q == StErr2);
  assign accept     = can_accept && HSEL && HREADY && HTRANS[1];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    unique case (st_q)
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) st_d = StData;
      end
      StErr1: st_d = StErr2;
      default: begin
        st_d = StIdle;
        if (accept) begin
          idx_d   = HADDR[IdxW+1:2];
          be_d    = a_be;
          write_d = HWRITE;
          cnt_d   = wait_cycles;
          if (addr_err)                 st_d = StErr1;
          else if (wait_cycles != 4'd0) st_d = StWait;
          else                          st_d = StData;
        end
      end
    endcase
    hready_d = !((st_d == StWait) || (st_d == StErr1));
    hresp_d  = ((st_d == StErr1) || (st_d == StErr2)) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign data_wr = (st_q == StData) && write_q;
  assign data_rd = (st_q == StData) && !write_q;
  assign rd_word = mem[idx_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (data_wr) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      if (data_rd) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        hrdata_q <= rd_word;
      end
    end
  end

  // No reset on the array so preloaded contents survive; reset clears st_q, killing data_wr.
  always_ff @(posedge clk) begin
    if (data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA    = data_rd ? rd_word : hrdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Two slaves on a shared AHB-Lite bus; a pipelined master issues transfers, a byte-level
// memory model predicts responses and a monitor compares them on completion.
module tb_ahb_slave_mem;

  localparam int unsigned Depth = 256;

  typedef struct packed {
    logic        err;
    logic        wr;
    int          lo;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel0, hsel1, hwrite, tgt, dsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  wc;
  logic [31:0] rd0, rd1;
  logic        ro0, ro1;
  logic [1:0]  rs0, rs1;
  logic [15:0] wcnt0, rcnt0, wcnt1, rcnt1;

  logic        hready_bus;
  logic [1:0]  hresp_bus;
  logic [31:0] hrdata_bus;

  assign hready_bus = dsel ? ro1 : ro0;
  assign hresp_bus  = dsel ? rs1 : rs0;
  assign hrdata_bus = dsel ? rd1 : rd0;

  ahb_slave_mem u_src (
    .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADY(hready_bus), .HWDATA(hwdata), .wait_cycles(wc),
    .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0), .wr_count(wcnt0), .rd_count(rcnt0)
  );

  ahb_slave_mem u_dst (
    .clk(clk), .rst(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HREADY(hready_bus), .HWDATA(hwdata), .wait_cycles(wc),
    .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1), .wr_count(wcnt1), .rd_count(rcnt1)
  );

  always #5 clk = ~clk;

  // Data-phase owner for the response mux.
  always @(posedge clk or negedge rst) begin
    if (!rst)            dsel <= 1'b0;
    else if (hready_bus) dsel <= tgt;
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem [2][Depth];
  int          mwr [2];
  int          mrd [2];
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          lo = 0;
  logic [31:0] last_rdata = '0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic void model_accept(input logic t, input logic [31:0] a, input logic w,
                                       input logic [2:0] sz, input logic [3:0] wcy,
                                       input logic [31:0] wd);
    exp_t        e;
    int unsigned nbytes, b;
    nbytes  = 32'd1 << sz;
    e.err   = (a >= Depth * 4) || (sz > 3'd2) || ((a % nbytes) != 0);
    e.wr    = w;
    e.lo    = e.err ? 1 : int'(wcy);
    e.rdata = '0;
    if (!e.err) begin
      if (w) begin
        for (int k = 0; k < int'(nbytes); k++) begin
          b = a + k;
          ref_mem[t][b / 4][8 * (b % 4) +: 8] = wd[8 * (b % 4) +: 8];
        end
        mwr[t]++;
      end else begin
        e.rdata = ref_mem[t][a / 4];
        mrd[t]++;
      end
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: one expected entry per accepted transfer, retired on the cycle HREADY rises.
  always @(negedge clk) begin
    if (rst && exp_q.size() != 0) begin
      if (!hready_bus) begin
        lo++;
        check("wait_resp", 32'(hresp_bus), exp_q[0].err ? 32'd1 : 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wait_len", 32'(lo), 32'(mon_e.lo));
        check("done_resp", 32'(hresp_bus), mon_e.err ? 32'd1 : 32'd0);
        if (!mon_e.err && !mon_e.wr) begin
          check("rdata", hrdata_bus, mon_e.rdata);
          last_rdata = hrdata_bus;
        end
        lo = 0;
      end
    end
  end

  task automatic issue(input logic t, input logic sel, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [3:0] wcy, input logic [31:0] wd,
                       input logic [1:0] tr);
    int guard;
    tgt    = t;
    hsel0  = sel && !t;
    hsel1  = sel && t;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
    wc     = wcy;
    htrans = tr;
    guard  = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!hready_bus && guard < 100);
    if (!hready_bus) check("ready_timeout", 32'(hready_bus), 32'd1);
    @(posedge clk);
    if (sel && tr[1]) model_accept(t, a, w, sz, wcy, wd);
    #1;
    hwdata = wd;
  endtask

  task automatic drain();
    int guard;
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    guard  = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_wr0"}, 32'(wcnt0), 32'(16'(mwr[0])));
    check({tag, "_rd0"}, 32'(rcnt0), 32'(16'(mrd[0])));
    check({tag, "_wr1"}, 32'(wcnt1), 32'(16'(mwr[1])));
    check({tag, "_rd1"}, 32'(rcnt1), 32'(16'(mrd[1])));
  endtask

  task automatic pulse_reset();
    hsel0  = 1'b0;
    hsel1  = 1'b0;
    htrans = 2'b00;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    mwr[0] = 0; mwr[1] = 0; mrd[0] = 0; mrd[1] = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    logic [2:0]  sz;
    logic [31:0] a;
    int          r;
    hsel0 = 0; hsel1 = 0; haddr = 0; hwdata = 0; htrans = 0; hwrite = 0; hsize = 0; wc = 0;
    tgt = 0;
    mwr[0] = 0; mwr[1] = 0; mrd[0] = 0; mrd[1] = 0;
    for (int i = 0; i < int'(Depth); i++) begin
      v = $urandom; u_src.mem[i] = v; ref_mem[0][i] = v;
      v = $urandom; u_dst.mem[i] = v; ref_mem[1][i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      v = 32'hA0B0_0000 + 32'(i * 17); u_src.mem[i] = v; ref_mem[0][i] = v;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rst_hreadyout", 32'(ro0), 32'd1);
    check("rst_hresp", 32'(rs0), 32'd0);
    check("rst_hrdata", rd0, 32'd0);
    check("rst_wr_count", 32'(wcnt0), 32'd0);
    check("rst_rd_count", 32'(rcnt0), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back zero-wait reads.
    issue(0, 1, 32'h0, 0, 3'd2, 4'd0, 32'h0, 2'b10);
    issue(0, 1, 32'h4, 0, 3'd2, 4'd0, 32'h0, 2'b11);
    issue(0, 1, 32'h8, 0, 3'd2, 4'd0, 32'h0, 2'b11);
    issue(0, 1, 32'hC, 0, 3'd2, 4'd0, 32'h0, 2'b11);
    drain();
    check("burst_rd_count", 32'(rcnt0), 32'd4);

    issue(0, 1, 32'h10, 1, 3'd2, 4'd3, 32'hDEAD_BEEF, 2'b10);
    drain();
    check("word_wr_mem4", u_src.mem[4], 32'hDEAD_BEEF);
    check("word_wr_count", 32'(wcnt0), 32'd1);

    u_src.mem[5] = 32'h1122_3344;
    ref_mem[0][5] = 32'h1122_3344;
    issue(0, 1, 32'h15, 1, 3'd0, 4'd0, {4{8'hAA}}, 2'b10);
    drain();
    check("byte_wr_mem5", u_src.mem[5], 32'h1122_AA44);
    issue(0, 1, 32'h16, 1, 3'd1, 4'd1, {2{16'hBEEF}}, 2'b10);
    drain();
    check("half_wr_mem5", u_src.mem[5], 32'hBEEF_AA44);

    issue(0, 1, 32'h400, 0, 3'd2, 4'd0, 32'h0, 2'b10);
    issue(0, 1, 32'h2, 1, 3'd2, 4'd2, 32'hFFFF_FFFF, 2'b10);
    drain();
    check("err_mem0", u_src.mem[0], ref_mem[0][0]);
    check("err_rd_count", 32'(rcnt0), 32'd4);
    check("err_wr_count", 32'(wcnt0), 32'd3);

    // Randomized traffic across both slaves.
    for (int n = 0; n < 250; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h400 + ($urandom_range(0, 255) << 2);
        2:       a = $urandom_range(0, 1023);
        default: a = $urandom_range(0, 1023) & ~((32'd1 << sz) - 32'd1);
      endcase
      r = $urandom_range(0, 9);
      issue(1'($urandom_range(0, 1)), r != 2, a, 1'($urandom_range(0, 1)), sz,
            4'($urandom_range(0, 3)), $urandom,
            (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'($urandom_range(2, 3)));
      if ($urandom_range(0, 15) == 0) drain();
    end
    drain();
    check_counts("rand");
    for (int i = 0; i < int'(Depth); i += 37) begin
      check("rand_mem_src", u_src.mem[i], ref_mem[0][i]);
      check("rand_mem_dst", u_dst.mem[i], ref_mem[1][i]);
    end

    // Copy 18 words from u_src to u_dst using the read data as write data.
    pulse_reset();
    for (int k = 0; k < 18; k++) begin
      issue(0, 1, 32'h100 + 32'(4 * k), 0, 3'd2, 4'((k % 2) * 2), 32'h0, 2'b10);
      drain();
      issue(1, 1, 32'h200 + 32'(4 * k), 1, 3'd2, 4'((k % 2) * 2), last_rdata, 2'b10);
      drain();
    end
    for (int k = 0; k < 18; k++) check("copy_word", u_dst.mem[128 + k], ref_mem[0][64 + k]);
    check("copy_wr_count", 32'(wcnt1), 32'd18);
    check("copy_rd_count", 32'(rcnt0), 32'd18);

    // Reset during the wait states of a write.
    u_src.mem[8] = 32'h5A5A_0008;
    tgt = 0; hsel0 = 1; haddr = 32'h20; hwrite = 1; hsize = 3'd2; wc = 4'd3; htrans = 2'b10;
    @(posedge clk);
    #1;
    hsel0 = 0; htrans = 2'b00; hwdata = 32'hCAFE_F00D;
    @(posedge clk);
    #2;
    check("pre_rst_hreadyout", 32'(ro0), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_hreadyout", 32'(ro0), 32'd1);
    check("mid_rst_hresp", 32'(rs0), 32'd0);
    check("mid_rst_hrdata", rd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_rst_mem8", u_src.mem[8], 32'h5A5A_0008);
    check("mid_rst_wr0", 32'(wcnt0), 32'd0);
    check("mid_rst_rd0", 32'(rcnt0), 32'd0);
    check("mid_rst_wr1", 32'(wcnt1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave memory that sits opposite the DMAC master port. It is the synthesizable responder counterpart to the DMAC's initiator side. It provides pipelined address/data phases and programmable wait states. It returns a two-cycle ERROR for out-of-range, misaligned or oversized accesses, supports byte-lane writes, and keeps read/write transfer counters for bench scoreboarding.

Parameters:
MEM_DEPTH, 256, number of 32-bit words
ADDR_BITS, 12, decoded offset width; offset = HADDR[ADDR_BITS-1:0]
CNT_W, 16, width of transfer counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
HSEL  in  1  slave select
HADDR  in  32  address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1=write
HSIZE  in  3  000 byte, 001 half, 010 word
HREADY  in  1  bus ready (address phase qualifier)
HWDATA  in  32  write data (data phase)
wait_cycles  in  4  wait states inserted per transfer, sampled in address phase
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  2  00 OKAY, 01 ERROR
wr_count  out  CNT_W  completed OKAY writes
rd_count  out  CNT_W  completed OKAY reads

Behaviour:
- Reset: HREADYOUT=1, HRESP=00, HRDATA=0, counters=0, FSM=IDLE. Memory contents are not cleared (the bench preloads them hierarchically via mem[]).
- Address phase accept: HSEL & HREADY & HTRANS[1] at a rising edge. On accept, register addr, write, size and wait_cycles.
- IDLE/BUSY or unselected: no accept; zero-wait OKAY.
- Error check at accept. Any of the following is an error:
  - offset[ADDR_BITS-1:2] >= MEM_DEPTH
  - any HADDR[31:ADDR_BITS] nonzero
  - HSIZE > 010
  - half with addr[0]=1
  - word with addr[1:0]!=0
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=00. On accept: error -> ERR1; wait_cycles>0 -> WAIT with cnt=wait_cycles; else -> DATA.
  - WAIT: HREADYOUT=0, HRESP=00, cnt decrements each cycle. When cnt reaches 1 -> DATA.
  - DATA (final cycle): HREADYOUT=1, HRESP=00.
    - Write: commit HWDATA at this edge to the enabled byte lanes. Lanes are selected by addr[1:0] and size (byte: one lane; half: lanes {1,0} or {3,2}; word: all). wr_count++.
    - Read: HRDATA = mem[idx] during this cycle. rd_count++.
    - A new accept in the same edge is honoured (back-to-back pipelining): go to ERR1/WAIT/DATA per the new transfer. Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01. Next -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. No memory write, no counter change. A new accept at this edge is honoured as in DATA.
- Latency: a zero-wait transfer completes the cycle after its address phase; N wait states add N cycles.
- HRDATA holds its last value outside read DATA cycles. It is never X after reset.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-transfer: pending write suppressed, FSM to IDLE immediately, outputs to reset values asynchronously.
- HTRANS=BUSY during a burst: no accept. A pending data phase still completes normally.

Test Plan:
- Preload mem[0..3]; NONSEQ/SEQ reads at 0x0,0x4,0x8,0xC, wait_cycles=0 -> HRDATA matches preload on consecutive cycles, HREADYOUT always 1, rd_count=4.
- Word write 0xDEADBEEF to 0x10 with wait_cycles=3 -> HREADYOUT low exactly 3 cycles, then high; mem[4]=0xDEADBEEF, wr_count=1.
- Byte write 0xAA to 0x15 over mem[5]=0x11223344 -> mem[5]=0x1122AA44. Half write 0xBEEF to 0x16 -> mem[5]=0xBEEFAA44.
- Read 0x400 (idx 256) and word access at 0x2 -> each gives HRESP=01 with HREADYOUT 0 then 1; counters unchanged; memory untouched.
- 18-word DMA-style copy: reads from one instance, writes to a second, wait_cycles toggling 0/2 -> destination equals source for all 18 words; wr_count=18.
- Assert rst low during WAIT of a write to 0x20 -> HREADYOUT=1, HRESP=00 immediately; mem[8] unchanged; counters 0.
